shiftreg_xfer_ctrl: RTL
=======================

Name: shiftreg_xfer_ctrl

Overview:
Sequencer for an N-bit load/shift register datapath with a serial-in port and an MSB serial-out port. It accepts a parallel word on a valid/ready handshake and loads it into the register. It then shifts the word out MSB-first over N shift ticks, paced by a programmable divider, while capturing sin. It finishes by presenting the received word with a one-cycle rx_valid pulse. It sits between the CPU-side register interface and a serial link.

Parameters:
N, 8, word width in bits; must be at least 2.
DIV, 1, clock cycles per shift tick; must be at least 1.
CW, $clog2(N), bit-counter width.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
tx_valid  in  1  a parallel word is offered.
tx_data  in  N  word to transmit.
tx_ready  out  1  block can accept a word; equals (state==IDLE).
sin  in  1  serial input, sampled on shift ticks.
sout  out  1  serial output; always equals q[N-1].
shift_tick  out  1  one-cycle strobe, high in the cycle whose closing edge performs a shift.
abort  in  1  synchronous cancel of the current transfer.
busy  out  1  equals (state==SHIFT).
bit_cnt  out  CW  number of bits shifted so far in the current word.
rx_valid  out  1  one-cycle pulse; rx_data holds a new word.
rx_data  out  N  last completed received word; held until the next completion.

Behaviour:
- Reset (reset==0, asynchronous), all registers cleared:
  - state=IDLE, q=0, bit_cnt=0, div_cnt=0.
  - rx_data=0, rx_valid=0.
  - Resulting outputs: tx_ready=1, busy=0, sout=0, shift_tick=0.
  - Reset asserted mid-transfer discards the word and raises no rx_valid.
- Two states: IDLE and SHIFT.
- IDLE:
  - tx_ready=1.
  - On the edge where tx_valid=1: q<=tx_data, bit_cnt<=0, div_cnt<=0, state<=SHIFT. Call this edge E0.
  - With tx_valid=0, q holds.
- SHIFT:
  - tx_ready=0; tx_valid is ignored and the offered word is not consumed.
  - div_cnt increments each cycle and wraps at DIV-1.
  - shift_tick = (state==SHIFT) & (div_cnt==DIV-1), combinational.
  - On each tick edge: q<={q[N-2:0],sin}, bit_cnt<=bit_cnt+1.
  - Each transmitted bit is therefore held on sout for exactly DIV cycles.
  - Tick edges fall at E0+k*DIV for k=1..N.
- Final tick (bit_cnt==N-1 at the tick edge):
  - rx_data<={q[N-2:0],sin}, rx_valid<=1, bit_cnt<=0, state<=IDLE.
  - rx_valid drops on the next edge unconditionally.
  - Back-to-back transfers are allowed: tx_ready is high in the same cycle rx_valid is high, so a new accept can occur at edge E0+N*DIV+1.
  - After completion q holds the received word, so sout = received MSB until the next load.
- abort=1 (priority over everything except reset):
  - In SHIFT: state<=IDLE, bit_cnt<=0, div_cnt<=0; q keeps its partially shifted value; no rx_valid; rx_data unchanged.
  - In IDLE: blocks acceptance for that cycle.
  - abort coinciding with the final tick edge: abort wins, no rx_valid.
- Received bit order: MSB first. The first sin sampled lands in rx_data[N-1].
- bit_cnt is never equal to N; it wraps to 0 on completion.

Test Plan:
1. Reset: hold reset=0 with random inputs, then release -> q=0, sout=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0; a reset pulse mid-shift returns all of these values immediately, asynchronously.
2. N=8, DIV=1: accept tx_data=8'hA5 at E0; drive sin with 8'h3C MSB-first on edges E1..E8 -> sout reads 1,0,1,0,0,1,0,1 in consecutive cycles; shift_tick high 8 cycles; rx_data=8'h3C with rx_valid high for exactly one cycle after E8; tx_ready=1 in that cycle.
3. N=8, DIV=3: send 8'h81 with sin=1 constant -> each sout bit held 3 cycles; shift_tick at every 3rd cycle; completion at E24; rx_data=8'hFF.
4. Busy handling: while busy, assert tx_valid with 8'h55 -> word not accepted, tx_ready=0, sout pattern unaffected; holding tx_valid through completion -> 8'h55 accepted at E8+1, giving back-to-back transfers with no idle gap beyond that one cycle.
5. Abort: N=8, DIV=1, abort pulsed after E4 -> state IDLE next edge, bit_cnt=0, no rx_valid, rx_data keeps its previous value; abort on the final tick edge -> no rx_valid.
6. N=32, DIV=2: send 32'hDEADBEEF looped back (sin=sout) -> rx_data=32'hDEADBEEF after edge E64.

Source files
------------

// File: rtl/shiftreg_xfer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shiftreg_xfer_if
//  Description : Host-side bundle for shiftreg_xfer_ctrl. It carries the
//                parallel transmit handshake, the received-word report, the
//                abort request and the status outputs.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    tx_valid  host -> ctrl  a parallel word is offered
//    tx_data   host -> ctrl  word to transmit (N bits)
//    tx_ready  ctrl -> host  controller is idle and can take a word
//    abort     host -> ctrl  synchronous cancel of the current transfer
//    busy      ctrl -> host  a word is being shifted
//    bit_cnt   ctrl -> host  bits shifted so far in the current word
//    rx_valid  ctrl -> host  one-cycle pulse, rx_data holds a new word
//    rx_data   ctrl -> host  last completed received word
//  Modports
//    master    the host (CPU-side register block or testbench)
//    slave     the controller
// ============================================================================
interface shiftreg_xfer_if #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
);
  logic          tx_valid;
  logic [N-1:0]  tx_data;
  logic          tx_ready;
  logic          abort;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          rx_valid;
  logic [N-1:0]  rx_data;

  modport master (
    output tx_valid,
    output tx_data,
    output abort,
    input  tx_ready,
    input  busy,
    input  bit_cnt,
    input  rx_valid,
    input  rx_data
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  abort,
    output tx_ready,
    output busy,
    output bit_cnt,
    output rx_valid,
    output rx_data
  );
endinterface
`default_nettype wire

// File: rtl/shiftreg_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shiftreg_xfer_ctrl
//  Description : Sequencer for an N-bit load/shift register. A word accepted
//                on the tx handshake is shifted out MSB-first on sout, one
//                bit per shift tick (every DIV clocks), while sin is shifted
//                in. After N ticks the received word is published on
//                rx_data with a one-cycle rx_valid pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   clock, rising edge
//    reset       in   asynchronous reset, active low
//    bus         --   host bundle (slave modport): tx handshake, abort,
//                     busy, bit_cnt, rx_valid, rx_data
//    sin         in   serial input, sampled on tick edges
//    sout        out  serial output, MSB of the shift register
//    shift_tick  out  high in the cycle whose closing edge shifts
// ============================================================================
module shiftreg_xfer_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 1,
  parameter int CW  = $clog2(N)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  shiftreg_xfer_if.slave     bus,
  input  wire logic          sin,
  output logic               sout,
  output logic               shift_tick
);

  // Divider counter needs at least one bit even when DIV == 1.
  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t        state_q,    state_d;
  logic [N-1:0]  q_q,        q_d;
  logic [CW-1:0] bit_cnt_q,  bit_cnt_d;
  logic [DW-1:0] div_cnt_q,  div_cnt_d;
  logic [N-1:0]  rx_data_q,  rx_data_d;
  logic          rx_valid_q, rx_valid_d;

  logic          tick;
  logic [N-1:0]  shifted;

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      q_q        <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // The divider sits at DIV_LAST in the last cycle of each bit period, so
  // the edge closing that cycle is the one that moves the register.
  assign tick    = (state_q == ST_SHIFT) && (div_cnt_q == DIV_LAST);
  assign shifted = {q_q[N-2:0], sin};

  // ------------------------------------------------------------------------
  // Next-state and datapath control
  // ------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;           // pulse: cleared unless completion re-asserts

    if (bus.abort) begin
      // Abort outranks load, shift and completion. The register keeps its
      // partially shifted contents; in IDLE it simply blocks the accept.
      if (state_q == ST_SHIFT) begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        div_cnt_d = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.tx_valid) begin
            q_d       = bus.tx_data;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            state_d   = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            div_cnt_d = '0;
            q_d       = shifted;
            if (bit_cnt_q == BIT_LAST) begin
              // Last bit: publish the word and free the host side. q keeps
              // the received word so sout shows its MSB until the next load.
              rx_data_d  = shifted;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              state_d    = ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign sout         = q_q[N-1];
  assign shift_tick   = tick;
  assign bus.tx_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.bit_cnt  = bit_cnt_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule
`default_nettype wire
